pipe_stall_ctrl: RTL and testbench
==================================

Name: pipe_stall_ctrl

Overview:
Central pipeline control unit for the 5-stage core. It merges stall requests from ID and EX and sequences multi-cycle EX operations (madd/msub, div) with a down-counter. It drives the per-stage stall vector that gates the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, and arbitrates flush against stall. It also keeps a saturating stall-cycle performance counter.

Parameters:
CNT_W, 6, width of the multi-cycle length and count (max 63 cycles)
PERF_W, 32, width of the stall-cycle performance counter

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
id_stall_req  in  1  ID load-use / hazard stall request, level, combinational
ex_op_start  in  1  EX holds a multi-cycle op; held high while the op sits in EX
ex_op_cycles  in  CNT_W  stall length N for the op; sampled only on an accepted start
ex_op_cancel  in  1  abort the in-flight multi-cycle op
flush_req  in  1  exception/flush request from MEM
stall  out  6  [0]=PC [1]=IF [2]=ID [3]=EX [4]=MEM [5]=WB; 1 = hold that stage
flush  out  1  clear all pipeline registers this cycle
ex_op_busy  out  1  sequencer in BUSY, or accepting a start this cycle
ex_op_done  out  1  one-cycle pulse: result valid, EX/MEM may capture
stall_cycles  out  PERF_W  count of cycles with stall!=0, saturating

Behaviour:
- Clock is clk. Reset is reset: synchronous, active-high.
- While reset=1, all outputs are 0 combinationally. At the next edge: state=IDLE, cnt=0, stall_cycles=0.
- Priority: reset > flush_req > EX stall > ID stall.
- Stall vector encodings:
  - EX stall active -> 6'b001111.
  - Else if id_stall_req -> 6'b000111.
  - Else 6'b000000.
  - MEM/WB are never stalled.
- Sequencer FSM states: IDLE, BUSY, DONE. Counter is cnt[CNT_W-1:0].
- IDLE:
  - ex_op_start=1 with N>0 is an accepted start. EX stall and ex_op_busy assert in the same cycle (combinational).
  - On an accepted start, cnt<=N-1. Next state is DONE if N==1, otherwise BUSY.
  - ex_op_start with N==0: no stall, no state change, no done.
- BUSY:
  - EX stall=1 and ex_op_busy=1. cnt decrements each cycle.
  - When cnt==1, go to DONE (cnt becomes 0).
  - Total EX-stall cycles per op = N, counting the start cycle.
- DONE:
  - stall from EX=0 (ID stall may still apply) and ex_op_done=1 for exactly one cycle. Next state is IDLE.
  - ex_op_start is ignored in BUSY and DONE, because the same instruction is still in EX.
- flush_req=1 in any state:
  - flush=1, stall=0 and ex_op_done=0 in the same cycle.
  - Next state IDLE, cnt<=0.
- ex_op_cancel in BUSY: EX stall is dropped the same cycle, next state IDLE, no done pulse. ex_op_cancel in IDLE or DONE has no effect.
- Simultaneous flush_req and accepted start: flush wins and the op is not started.
- stall_cycles increments on each edge where stall!=0 and reset=0. It saturates at all-ones.
- Outputs stall, flush, ex_op_busy and ex_op_done are combinational from registered state plus current inputs. No new combinational path from any output back to any input is allowed.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - the stall encodings STALL_NONE=6'b000000, STALL_ID=6'b000111, STALL_EX=6'b001111;
  - the stage index constants;
  - the sequencer state enum {IDLE, BUSY, DONE}.
- One sub-module, ex_op_seq: FSM plus cnt, producing ex_stall, ex_op_busy and ex_op_done. The top level performs priority merging, flush and the perf counter.

Test Plan:
- Reset then idle, no requests -> stall=0, flush=0, stall_cycles=0. Drive id_stall_req=1 for 2 cycles -> stall=6'b000111 for 2 cycles, stall_cycles=2.
- ex_op_start held with N=5 -> stall=6'b001111 for exactly 5 cycles. Then ex_op_done=1 for 1 cycle with stall=0, then IDLE. A held start causes no restart.
- N=1 -> one stall cycle, done on the next. N=0 -> no stall, no done.
- N=33 (div) with flush_req pulsed on stall cycle 10 -> that cycle flush=1, stall=0. No done pulse; FSM IDLE next cycle.
- N=4 with ex_op_cancel on cycle 2 -> stall drops in that cycle, no ex_op_done. id_stall_req asserted concurrently yields 6'b000111.
- Reset asserted on cycle 3 of an N=8 op -> outputs 0 during reset. After release, idle with stall=0 and stall_cycles=0. Force stall_cycles to its max -> it holds at all-ones.

Source files
------------

// File: rtl/pipe_stall_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl_pkg
// Purpose  : Shared stall encodings, stage indices and sequencer state type
//            for the pipeline stall controller.
// Revision : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

  // Stage positions inside the stall vector
  localparam int STG_PC  = 0;
  localparam int STG_IF  = 1;
  localparam int STG_ID  = 2;
  localparam int STG_EX  = 3;
  localparam int STG_MEM = 4;
  localparam int STG_WB  = 5;

  localparam int STALL_W = 6;

  // Stall vector encodings; MEM and WB are never held
  localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
  localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
  localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;

  // Multi-cycle EX operation sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } seq_state_t;

endpackage : pipe_ctrl_pkg
`default_nettype wire

// File: rtl/pipe_stall_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stall_ctrl_if
// Purpose  : Request/control bundle between the pipeline stages (master)
//            and the central stall controller (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface pipe_stall_ctrl_if #(
  parameter int CNT_W  = 6,
  parameter int PERF_W = 32
);
  logic              id_stall_req;
  logic              ex_op_start;
  logic [CNT_W-1:0]  ex_op_cycles;
  logic              ex_op_cancel;
  logic              flush_req;
  logic [5:0]        stall;
  logic              flush;
  logic              ex_op_busy;
  logic              ex_op_done;
  logic [PERF_W-1:0] stall_cycles;

  modport master (
    output id_stall_req, ex_op_start, ex_op_cycles, ex_op_cancel, flush_req,
    input  stall, flush, ex_op_busy, ex_op_done, stall_cycles
  );

  modport slave (
    input  id_stall_req, ex_op_start, ex_op_cycles, ex_op_cancel, flush_req,
    output stall, flush, ex_op_busy, ex_op_done, stall_cycles
  );
endinterface : pipe_stall_ctrl_if
`default_nettype wire

// File: rtl/pipe_stall_ctrl_ex_op_seq.sv
`default_nettype none
// ============================================================================
// Module   : ex_op_seq
// Purpose  : Multi-cycle EX operation sequencer. Holds EX for N cycles
//            (counting the start cycle) and then pulses done for one cycle.
// Revision : 1.0 - initial release
// ============================================================================
module ex_op_seq
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = 6
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic             ex_op_start,
  input  wire logic [CNT_W-1:0] ex_op_cycles,
  input  wire logic             ex_op_cancel,
  input  wire logic             flush_req,
  output logic                  ex_stall,
  output logic                  ex_op_busy,
  output logic                  ex_op_done
);

  seq_state_t       r_state;
  seq_state_t       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_accept;

  // A start is only taken from IDLE, with a non-zero length, and never
  // alongside a flush (the flushed instruction must not begin an op).
  assign w_accept = (r_state == IDLE) && ex_op_start &&
                    (ex_op_cycles != '0) && !flush_req;

  // State register and remaining-cycle counter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state: flush dominates, cancel aborts BUSY, count down to DONE
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (flush_req) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            w_cnt_nxt   = ex_op_cycles - CNT_W'(1);
            w_state_nxt = (ex_op_cycles == CNT_W'(1)) ? DONE : BUSY;
          end
        end
        BUSY: begin
          if (ex_op_cancel) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
          end else if (r_cnt == CNT_W'(1)) begin
            w_state_nxt = DONE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt   = r_cnt - CNT_W'(1);
          end
        end
        DONE: begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end
        default: begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Outputs: stall on the accept cycle and through BUSY unless cancelled
  always_comb begin
    ex_stall   = w_accept || ((r_state == BUSY) && !ex_op_cancel);
    ex_op_busy = w_accept || (r_state == BUSY);
    ex_op_done = (r_state == DONE) && !flush_req;
  end

endmodule : ex_op_seq
`default_nettype wire

// File: rtl/pipe_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stall_ctrl
// Purpose  : Central pipeline control: merges ID/EX stall requests, arbitrates
//            flush over stall, and keeps a saturating stall-cycle counter.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W  = 6,
  parameter int PERF_W = 32
) (
  input wire logic          clk,
  input wire logic          reset,
  pipe_stall_ctrl_if.slave  bus
);

  logic              w_ex_stall;
  logic              w_ex_busy;
  logic              w_ex_done;
  logic [5:0]        w_stall;
  logic [PERF_W-1:0] r_stall_cycles;

  ex_op_seq #(
    .CNT_W (CNT_W)
  ) u_ex_op_seq (
    .clk          (clk),
    .reset        (reset),
    .ex_op_start  (bus.ex_op_start),
    .ex_op_cycles (bus.ex_op_cycles),
    .ex_op_cancel (bus.ex_op_cancel),
    .flush_req    (bus.flush_req),
    .ex_stall     (w_ex_stall),
    .ex_op_busy   (w_ex_busy),
    .ex_op_done   (w_ex_done)
  );

  // Priority merge: reset > flush > EX stall > ID stall
  always_comb begin
    w_stall = STALL_NONE;
    if (reset || bus.flush_req) begin
      w_stall = STALL_NONE;
    end else if (w_ex_stall) begin
      w_stall = STALL_EX;
    end else if (bus.id_stall_req) begin
      w_stall = STALL_ID;
    end
  end

  // Saturating count of cycles in which any stage was held
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cycles <= '0;
    end else if ((w_stall != STALL_NONE) && (r_stall_cycles != '1)) begin
      r_stall_cycles <= r_stall_cycles + PERF_W'(1);
    end
  end

  // Drive the bus; every output reads zero while reset is held
  always_comb begin
    bus.stall        = w_stall;
    bus.flush        = !reset && bus.flush_req;
    bus.ex_op_busy   = !reset && w_ex_busy;
    bus.ex_op_done   = !reset && w_ex_done;
    bus.stall_cycles = reset ? '0 : r_stall_cycles;
  end

endmodule : pipe_stall_ctrl
`default_nettype wire

// File: tb/tb_pipe_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stall_ctrl
// Purpose  : Self-checking bench for pipe_stall_ctrl: directed scenarios plus
//            randomized traffic against a cycle-count reference model, and a
//            narrow-counter instance for saturation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_stall_ctrl;

  logic clk;
  logic reset;
  logic reset_s;

  pipe_stall_ctrl_if #(.CNT_W(6), .PERF_W(32)) bus ();
  pipe_stall_ctrl_if #(.CNT_W(6), .PERF_W(4))  sbus ();

  pipe_stall_ctrl #(.CNT_W(6), .PERF_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  pipe_stall_ctrl #(.CNT_W(6), .PERF_W(4)) dut_sat (
    .clk   (clk),
    .reset (reset_s),
    .bus   (sbus)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  // Reference model: EX cycles still owed after this one, a pending done
  // pulse, and the stall-cycle total
  int      owed     = 0;
  bit      done_due = 0;
  longint  perf     = 0;
  localparam longint PERF_MAX = 64'hFFFF_FFFF;

  // Single comparison point
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, check outputs mid-cycle, then advance the model
  task automatic cycle(input bit rst, input bit id, input bit st, input int n,
                       input bit can, input bit fl);
    bit     in_op, accept, ex_st, e_busy, e_done;
    logic [5:0] e_stall;
    @(negedge clk);
    reset             = rst;
    bus.id_stall_req  = id;
    bus.ex_op_start   = st;
    bus.ex_op_cycles  = 6'(n);
    bus.ex_op_cancel  = can;
    bus.flush_req     = fl;
    #1;
    in_op  = (owed > 0) && !done_due;
    accept = !in_op && !done_due && st && (n > 0) && !fl;
    ex_st  = accept || (in_op && !can);
    e_busy = !rst && (accept || in_op);
    e_done = !rst && done_due && !fl;
    if (rst || fl)     e_stall = 6'b000000;
    else if (ex_st)    e_stall = 6'b001111;
    else if (id)       e_stall = 6'b000111;
    else               e_stall = 6'b000000;
    check("stall",        32'(bus.stall),      32'(e_stall));
    check("flush",        32'(bus.flush),      32'(!rst && fl));
    check("ex_op_busy",   32'(bus.ex_op_busy), 32'(e_busy));
    check("ex_op_done",   32'(bus.ex_op_done), 32'(e_done));
    check("stall_cycles", bus.stall_cycles,    rst ? 32'd0 : 32'(perf));
    @(posedge clk);
    if (rst) begin
      owed = 0; done_due = 0; perf = 0;
    end else begin
      if (e_stall != 0 && perf < PERF_MAX) perf++;
      if (fl) begin
        owed = 0; done_due = 0;
      end else if (accept) begin
        owed = n - 1;
        done_due = (n == 1);
      end else if (in_op) begin
        if (can) owed = 0;
        else begin
          owed--;
          if (owed == 0) done_due = 1;
        end
      end else begin
        done_due = 0;
      end
    end
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cycle(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1; reset_s = 1;
    bus.id_stall_req = 0; bus.ex_op_start = 0; bus.ex_op_cycles = '0;
    bus.ex_op_cancel = 0; bus.flush_req = 0;
    sbus.id_stall_req = 0; sbus.ex_op_start = 0; sbus.ex_op_cycles = '0;
    sbus.ex_op_cancel = 0; sbus.flush_req = 0;

    // Reset, idle, then two ID stall cycles
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    idle(2);
    cycle(0, 1, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0);
    idle(1);
    check("perf_after_id", bus.stall_cycles, 32'd2);

    // N=5 with start held through done: 5 stalls, one done, no restart
    for (int i = 0; i < 6; i++) cycle(0, 0, 1, 5, 0, 0);
    idle(2);

    // N=1 then N=0
    for (int i = 0; i < 2; i++) cycle(0, 0, 1, 1, 0, 0);
    idle(1);
    for (int i = 0; i < 2; i++) cycle(0, 0, 1, 0, 0, 0);
    idle(1);

    // N=33 with flush on stall cycle 10
    for (int i = 0; i < 9; i++) cycle(0, 0, 1, 33, 0, 0);
    cycle(0, 0, 1, 33, 0, 1);
    idle(3);

    // N=4 with cancel on cycle 2 while ID also requests a stall
    cycle(0, 0, 1, 4, 0, 0);
    cycle(0, 1, 1, 4, 1, 0);
    idle(3);

    // Reset on cycle 3 of an N=8 op
    cycle(0, 0, 1, 8, 0, 0);
    cycle(0, 0, 1, 8, 0, 0);
    cycle(1, 0, 1, 8, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    idle(2);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      cycle(($urandom % 97) == 0, ($urandom % 3) == 0, ($urandom % 3) == 0,
            int'($urandom % 8), ($urandom % 9) == 0, ($urandom % 17) == 0);
    end

    // Saturation on the 4-bit counter instance
    @(negedge clk);
    reset_s = 1;
    @(posedge clk);
    @(negedge clk);
    reset_s = 0;
    #1;
    check("sat_reset", 32'(sbus.stall_cycles), 32'd0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      sbus.id_stall_req = 1;
      #1;
      check("sat_stall", 32'(sbus.stall), 32'h07);
      check("sat_count", 32'(sbus.stall_cycles), (i < 15) ? 32'(i) : 32'd15);
      @(posedge clk);
    end
    @(negedge clk);
    sbus.id_stall_req = 0;
    #1;
    check("sat_hold", 32'(sbus.stall_cycles), 32'd15);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_pipe_stall_ctrl
`default_nettype wire
